alu_reservation_station: RTL

- Reservation station for the integer ALU in the Tomasulo core.
- Sits directly downstream of the register file:
  - Issue logic reads value/label pairs for both source registers and writes them into a free entry.
  - The station hands that entry's label back to the register file as the destination rename label.
- Entries snoop the common data bus (CDB) broadcast. Ready entries are dispatched one per cycle to the ALU.
- An entry is released only when its own label is broadcast on the CDB. This keeps labels unique while results are in flight.

---
 rtl/alu_reservation_station_pkg.sv | 33 +++
 rtl/alu_reservation_station_rs_entry.sv | 115 +++++++++++
 rtl/alu_reservation_station.sv | 137 +++++++++++++
 3 files changed

// File: rtl/alu_reservation_station_pkg.sv
// Shared definitions for the integer ALU reservation station.
// Covers label width, the "no label" value, entry state encodings and ALU opcodes.
package alu_reservation_station_pkg;

    localparam int LABEL_W = 4;

    // Label 0 means "value already valid"; no entry ever owns it.
    localparam logic [LABEL_W-1:0] NO_LABEL = '0;

    typedef enum logic [1:0] {
        RS_FREE  = 2'd0,
        RS_WAIT  = 2'd1,
        RS_READY = 2'd2,
        RS_EXEC  = 2'd3
    } rs_state_e;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3;
    localparam logic [3:0] ALU_XOR = 4'd4;
    localparam logic [3:0] ALU_SLL = 4'd5;
    localparam logic [3:0] ALU_SRL = 4'd6;
    localparam logic [3:0] ALU_SLT = 4'd7;

    // True when a valid broadcast carries the (nonzero) label an operand waits on.
    function automatic logic label_hit(input logic en,
                                       input logic [LABEL_W-1:0] bc_lbl,
                                       input logic [LABEL_W-1:0] q);
        return en && (q != NO_LABEL) && (q == bc_lbl);
    endfunction

endpackage

// File: rtl/alu_reservation_station_rs_entry.sv
// One reservation station entry: state machine, operand capture and CDB snoop.
// The entry owns the fixed label MY_LABEL and returns to FREE only on its own broadcast.
module alu_reservation_station_rs_entry
    import alu_reservation_station_pkg::*;
#(
    parameter int                 OPW      = 4,
    parameter logic [LABEL_W-1:0] MY_LABEL = 4'd1
) (
    input  logic               clk,
    input  logic               nRST,
    input  logic               alloc,
    input  logic               grant,
    input  logic [OPW-1:0]     issue_op,
    input  logic [31:0]        issue_vj,
    input  logic [LABEL_W-1:0] issue_qj,
    input  logic [31:0]        issue_vk,
    input  logic [LABEL_W-1:0] issue_qk,
    input  logic               bc_en,
    input  logic [LABEL_W-1:0] bc_label,
    input  logic [31:0]        bc_data,
    output logic [1:0]         state,
    output logic [OPW-1:0]     op,
    output logic [31:0]        vj,
    output logic [31:0]        vk
);

    rs_state_e          state_q, state_d;
    logic [OPW-1:0]     op_q, op_d;
    logic [31:0]        vj_q, vj_d, vk_q, vk_d;
    logic [LABEL_W-1:0] qj_q, qj_d, qk_q, qk_d;

    // Next-state: capture on allocation (with same-cycle CDB forwarding), snoop while waiting.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        vj_d    = vj_q;
        vk_d    = vk_q;
        qj_d    = qj_q;
        qk_d    = qk_q;
        unique case (state_q)
            RS_FREE: begin
                if (alloc) begin
                    op_d = issue_op;
                    if (label_hit(bc_en, bc_label, issue_qj)) begin
                        vj_d = bc_data;
                        qj_d = NO_LABEL;
                    end else begin
                        vj_d = issue_vj;
                        qj_d = issue_qj;
                    end
                    if (label_hit(bc_en, bc_label, issue_qk)) begin
                        vk_d = bc_data;
                        qk_d = NO_LABEL;
                    end else begin
                        vk_d = issue_vk;
                        qk_d = issue_qk;
                    end
                    state_d = (qj_d == NO_LABEL && qk_d == NO_LABEL) ? RS_READY : RS_WAIT;
                end
            end
            RS_WAIT: begin
                if (label_hit(bc_en, bc_label, qj_q)) begin
                    vj_d = bc_data;
                    qj_d = NO_LABEL;
                end
                if (label_hit(bc_en, bc_label, qk_q)) begin
                    vk_d = bc_data;
                    qk_d = NO_LABEL;
                end
                if (qj_d == NO_LABEL && qk_d == NO_LABEL) begin
                    state_d = RS_READY;
                end
            end
            RS_READY: begin
                if (grant) begin
                    state_d = RS_EXEC;
                end
            end
            RS_EXEC: begin
                if (bc_en && bc_label == MY_LABEL) begin
                    state_d = RS_FREE;
                end
            end
        endcase
    end

    // Entry registers, cleared asynchronously.
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            state_q <= RS_FREE;
            op_q    <= '0;
            vj_q    <= '0;
            vk_q    <= '0;
            qj_q    <= NO_LABEL;
            qk_q    <= NO_LABEL;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            vj_q    <= vj_d;
            vk_q    <= vk_d;
            qj_q    <= qj_d;
            qk_q    <= qk_d;
        end
    end

    // A broadcast of our label is only meaningful while our result is in flight.
    illegal_own_broadcast: assert property (@(posedge clk) disable iff (!nRST)
        !(bc_en && bc_label == MY_LABEL && state_q != RS_EXEC));

    assign state = state_q;
    assign op    = op_q;
    assign vj    = vj_q;
    assign vk    = vk_q;

endmodule

// File: rtl/alu_reservation_station.sv
// ALU reservation station top: free/ready priority encoders, entry array, dispatch register.
// Allocation and dispatch both pick the lowest-index candidate entry.
module alu_reservation_station
    import alu_reservation_station_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int LABEL_BASE = 1,
    parameter int OPW        = 4
) (
    input  logic               clk,
    input  logic               nRST,
    input  logic               issue_valid,
    output logic               issue_ready,
    input  logic [OPW-1:0]     issue_op,
    input  logic [31:0]        issue_vj,
    input  logic [LABEL_W-1:0] issue_qj,
    input  logic [31:0]        issue_vk,
    input  logic [LABEL_W-1:0] issue_qk,
    output logic [LABEL_W-1:0] issue_label,
    input  logic               bc_en,
    input  logic [LABEL_W-1:0] bc_label,
    input  logic [31:0]        bc_data,
    output logic               disp_valid,
    input  logic               disp_ready,
    output logic [OPW-1:0]     disp_op,
    output logic [31:0]        disp_a,
    output logic [31:0]        disp_b,
    output logic [LABEL_W-1:0] disp_label
);

    logic [1:0]     ent_state [DEPTH];
    logic [OPW-1:0] ent_op    [DEPTH];
    logic [31:0]    ent_vj    [DEPTH];
    logic [31:0]    ent_vk    [DEPTH];

    logic [DEPTH-1:0] alloc_vec, grant_vec;
    logic             any_free, any_ready, load_en;
    logic [2:0]       free_idx, ready_idx;

    logic               disp_valid_q, disp_valid_d;
    logic [OPW-1:0]     disp_op_q, disp_op_d;
    logic [31:0]        disp_a_q, disp_a_d, disp_b_q, disp_b_d;
    logic [LABEL_W-1:0] disp_label_q, disp_label_d;

    for (genvar g = 0; g < DEPTH; g++) begin : g_entry
        alu_reservation_station_rs_entry #(
            .OPW      (OPW),
            .MY_LABEL (4'(LABEL_BASE + g))
        ) u_entry (
            .clk      (clk),
            .nRST     (nRST),
            .alloc    (alloc_vec[g]),
            .grant    (grant_vec[g]),
            .issue_op (issue_op),
            .issue_vj (issue_vj),
            .issue_qj (issue_qj),
            .issue_vk (issue_vk),
            .issue_qk (issue_qk),
            .bc_en    (bc_en),
            .bc_label (bc_label),
            .bc_data  (bc_data),
            .state    (ent_state[g]),
            .op       (ent_op[g]),
            .vj       (ent_vj[g]),
            .vk       (ent_vk[g])
        );
    end

    // Lowest-index FREE and READY entries; scanning downward lets the lowest index win.
    always_comb begin
        any_free  = 1'b0;
        any_ready = 1'b0;
        free_idx  = '0;
        ready_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (ent_state[i] == RS_FREE) begin
                any_free = 1'b1;
                free_idx = 3'(i);
            end
            if (ent_state[i] == RS_READY) begin
                any_ready = 1'b1;
                ready_idx = 3'(i);
            end
        end
    end

    // Allocation strobes, dispatch grants and the dispatch register's next value.
    always_comb begin
        alloc_vec    = '0;
        grant_vec    = '0;
        load_en      = !disp_valid_q || disp_ready;
        disp_valid_d = disp_valid_q;
        disp_op_d    = disp_op_q;
        disp_a_d     = disp_a_q;
        disp_b_d     = disp_b_q;
        disp_label_d = disp_label_q;
        for (int i = 0; i < DEPTH; i++) begin
            alloc_vec[i] = issue_valid && any_free && (free_idx == 3'(i));
            grant_vec[i] = load_en && any_ready && (ready_idx == 3'(i));
            if (grant_vec[i]) begin
                disp_op_d    = ent_op[i];
                disp_a_d     = ent_vj[i];
                disp_b_d     = ent_vk[i];
                disp_label_d = 4'(LABEL_BASE + i);
            end
        end
        if (load_en) begin
            disp_valid_d = any_ready;
        end
    end

    // Dispatch register, cleared asynchronously.
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            disp_valid_q <= 1'b0;
            disp_op_q    <= '0;
            disp_a_q     <= '0;
            disp_b_q     <= '0;
            disp_label_q <= NO_LABEL;
        end else begin
            disp_valid_q <= disp_valid_d;
            disp_op_q    <= disp_op_d;
            disp_a_q     <= disp_a_d;
            disp_b_q     <= disp_b_d;
            disp_label_q <= disp_label_d;
        end
    end

    assign issue_ready = any_free;
    assign issue_label = any_free ? (4'(LABEL_BASE) + {1'b0, free_idx}) : NO_LABEL;
    assign disp_valid  = disp_valid_q;
    assign disp_op     = disp_op_q;
    assign disp_a      = disp_a_q;
    assign disp_b      = disp_b_q;
    assign disp_label  = disp_label_q;

endmodule
